// File: rtl/mpu_op_scheduler_pkg.sv
// Shared types and constants for the MPU operation scheduler.
// The matrix register file width lives here so the scheduler and
// its queue agree on how wide each packed operation is.
package mpu_op_scheduler_pkg;

    localparam int MATRIX_REG_BITS = 2;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_MULT  = 2'd3
    } mpu_sched_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_LD_XFER,
        S_ST_WAIT,
        S_ST_XFER,
        S_MU_WAIT
    } sched_state_t;

endpackage

// File: rtl/mpu_op_scheduler_fifo.sv
// Synchronous operation queue with registered full/empty flags.
// The head entry is presented combinationally (fall-through) so the
// scheduler can inspect it for hazards before deciding to pop.
module mpu_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset; flushing the pointers is enough to empty the queue
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mpu_op_scheduler.sv
// Queues MPU operations and issues them one at a time to the loader,
// storer and multiply dispatcher. One multiply may stay outstanding while
// independent loads and stores proceed; a scoreboard blocks register hazards.
module mpu_op_scheduler
    import mpu_op_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int REG_BITS   = MATRIX_REG_BITS + 1,
    parameter int NUM_REGS   = 2 ** REG_BITS,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          op_code,
    input  logic [REG_BITS-1:0] op_src0,
    input  logic [REG_BITS-1:0] op_src1,
    input  logic [REG_BITS-1:0] op_dest,
    output logic                load_req,
    output logic [REG_BITS-1:0] load_addr,
    input  logic                mem_load_ack,
    output logic                store_req,
    output logic [REG_BITS-1:0] store_addr,
    input  logic                mem_store_en,
    output logic                start_mult,
    output logic [REG_BITS-1:0] src_addr_0,
    output logic [REG_BITS-1:0] src_addr_1,
    output logic [REG_BITS-1:0] dest_addr,
    input  logic                disp_ack,
    input  logic                collector_finished,
    output logic [NUM_REGS-1:0] busy_regs,
    output logic                idle,
    output logic                timeout_err
);

    localparam int          EW       = 2 + 3 * REG_BITS;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    sched_state_t        state;
    logic                fifo_full;
    logic                fifo_empty;
    logic [EW-1:0]       head;
    mpu_sched_op_t       head_code;
    logic [REG_BITS-1:0] head_src0;
    logic [REG_BITS-1:0] head_src1;
    logic [REG_BITS-1:0] head_dest;
    logic                hazard;
    logic                issue;
    logic                mult_out;
    logic [REG_BITS-1:0] mul_a;
    logic [REG_BITS-1:0] mul_b;
    logic [REG_BITS-1:0] mul_d;
    logic [NUM_REGS-1:0] busy_vec;
    logic [15:0]         tmo_cnt;
    logic                tmo_done;

    mpu_sched_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_valid),
        .wdata ({op_code, op_src0, op_src1, op_dest}),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign op_ready  = !fifo_full;
    assign head_code = mpu_sched_op_t'(head[EW-1 -: 2]);
    assign head_src0 = head[3*REG_BITS-1 -: REG_BITS];
    assign head_src1 = head[2*REG_BITS-1 -: REG_BITS];
    assign head_dest = head[REG_BITS-1:0];
    assign tmo_done  = (tmo_cnt == TMO_LAST);
    assign issue     = (state == S_IDLE) && !fifo_empty && !hazard;
    assign busy_regs = busy_vec;
    assign idle      = fifo_empty && (state == S_IDLE) && !mult_out;

    // Registers touched by the outstanding multiply
    always_comb begin
        busy_vec = '0;
        if (mult_out) begin
            busy_vec[mul_a] = 1'b1;
            busy_vec[mul_b] = 1'b1;
            busy_vec[mul_d] = 1'b1;
        end
    end

    // Head-of-queue hazard check against the pre-clear scoreboard
    always_comb begin
        hazard = 1'b0;
        case (head_code)
            OP_LOAD:  hazard = busy_vec[head_dest];
            OP_STORE: hazard = mult_out && (head_src0 == mul_d);
            OP_MULT:  hazard = mult_out;
            default:  hazard = 1'b0;
        endcase
    end

    // Issue FSM with registered handshake outputs, scoreboard and timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            load_req    <= 1'b0;
            load_addr   <= '0;
            store_req   <= 1'b0;
            store_addr  <= '0;
            start_mult  <= 1'b0;
            src_addr_0  <= '0;
            src_addr_1  <= '0;
            dest_addr   <= '0;
            mult_out    <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_d       <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (collector_finished) mult_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (issue) begin
                        case (head_code)
                            OP_LOAD: begin
                                state     <= S_LD_WAIT;
                                load_req  <= 1'b1;
                                load_addr <= head_dest;
                            end
                            OP_STORE: begin
                                state      <= S_ST_WAIT;
                                store_req  <= 1'b1;
                                store_addr <= head_src0;
                            end
                            OP_MULT: begin
                                state      <= S_MU_WAIT;
                                start_mult <= 1'b1;
                                src_addr_0 <= head_src0;
                                src_addr_1 <= head_src1;
                                dest_addr  <= head_dest;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_LD_WAIT: begin
                    if (mem_load_ack) begin
                        state   <= S_LD_XFER;
                        tmo_cnt <= '0;
                    end else if (tmo_done) begin
                        load_req    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_LD_XFER: begin
                    if (!mem_load_ack || tmo_done) begin
                        load_req <= 1'b0;
                        state    <= S_IDLE;
                        if (mem_load_ack) timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_ST_WAIT: begin
                    if (mem_store_en) begin
                        state   <= S_ST_XFER;
                        tmo_cnt <= '0;
                    end else if (tmo_done) begin
                        store_req   <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_ST_XFER: begin
                    if (!mem_store_en || tmo_done) begin
                        store_req <= 1'b0;
                        state     <= S_IDLE;
                        if (mem_store_en) timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_MU_WAIT: begin
                    if (disp_ack) begin
                        start_mult <= 1'b0;
                        mult_out   <= 1'b1;
                        mul_a      <= src_addr_0;
                        mul_b      <= src_addr_1;
                        mul_d      <= dest_addr;
                        state      <= S_IDLE;
                    end else if (tmo_done) begin
                        start_mult  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_op_scheduler.sv
// Directed self-checking bench for the MPU operation scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mpu_op_scheduler;

    localparam int RB = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    op_code = '0;
    logic [RB-1:0] op_src0 = '0;
    logic [RB-1:0] op_src1 = '0;
    logic [RB-1:0] op_dest = '0;
    logic          load_req;
    logic [RB-1:0] load_addr;
    logic          mem_load_ack = 1'b0;
    logic          store_req;
    logic [RB-1:0] store_addr;
    logic          mem_store_en = 1'b0;
    logic          start_mult;
    logic [RB-1:0] src_addr_0;
    logic [RB-1:0] src_addr_1;
    logic [RB-1:0] dest_addr;
    logic          disp_ack = 1'b0;
    logic          collector_finished = 1'b0;
    logic [NR-1:0] busy_regs;
    logic          idle;
    logic          timeout_err;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpu_op_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .op_valid           (op_valid),
        .op_ready           (op_ready),
        .op_code            (op_code),
        .op_src0            (op_src0),
        .op_src1            (op_src1),
        .op_dest            (op_dest),
        .load_req           (load_req),
        .load_addr          (load_addr),
        .mem_load_ack       (mem_load_ack),
        .store_req          (store_req),
        .store_addr         (store_addr),
        .mem_store_en       (mem_store_en),
        .start_mult         (start_mult),
        .src_addr_0         (src_addr_0),
        .src_addr_1         (src_addr_1),
        .dest_addr          (dest_addr),
        .disp_ack           (disp_ack),
        .collector_finished (collector_finished),
        .busy_regs          (busy_regs),
        .idle               (idle),
        .timeout_err        (timeout_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one operation and hold it until the queue has taken it
    task automatic applyStimulus(input logic [1:0] code, input logic [RB-1:0] s0,
                                 input logic [RB-1:0] s1, input logic [RB-1:0] d);
        int n;
        n        = 0;
        op_valid = 1'b1;
        op_code  = code;
        op_src0  = s0;
        op_src1  = s1;
        op_dest  = d;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("push_ready", {31'd0, op_ready}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Issue a multiply from an idle scheduler and let the dispatcher accept it
    task automatic issueMult(input logic [RB-1:0] a, input logic [RB-1:0] b, input logic [RB-1:0] d);
        applyStimulus(2'd3, a, b, d);
        @(negedge clk);
        checkOutput("mult_start", {31'd0, start_mult}, 32'd1);
        checkOutput("mult_addrs", {23'd0, src_addr_0, src_addr_1, dest_addr}, {23'd0, a, b, d});
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        checkOutput("mult_accepted", {31'd0, start_mult}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("rst_ready", {31'd0, op_ready}, 32'd1);
        checkOutput("rst_idle", {31'd0, idle}, 32'd1);
        checkOutput("rst_outs", {28'd0, load_req, store_req, start_mult, timeout_err}, 32'd0);
        checkOutput("rst_busy", {24'd0, busy_regs}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Plain load handshake
        applyStimulus(2'd1, 3'd0, 3'd0, 3'd2);
        checkOutput("t1_ld_pre", {31'd0, load_req}, 32'd0);
        @(negedge clk);
        checkOutput("t1_ld_req", {31'd0, load_req}, 32'd1);
        checkOutput("t1_ld_addr", {29'd0, load_addr}, 32'd2);
        checkOutput("t1_busy_flag", {31'd0, idle}, 32'd0);
        mem_load_ack = 1'b1;
        stepCycles(4);
        checkOutput("t1_ld_xfer", {28'd0, load_req, load_addr}, 32'hA);
        mem_load_ack = 1'b0;
        @(negedge clk);
        checkOutput("t1_ld_done", {31'd0, load_req}, 32'd0);
        checkOutput("t1_idle", {31'd0, idle}, 32'd1);

        // Store of a multiply destination waits for the collector
        issueMult(3'd0, 3'd1, 3'd2);
        checkOutput("t2_busy", {24'd0, busy_regs}, 32'h07);
        applyStimulus(2'd2, 3'd2, 3'd0, 3'd0);
        stepCycles(3);
        checkOutput("t2_st_stall", {31'd0, store_req}, 32'd0);
        checkOutput("t2_busy_stall", {24'd0, busy_regs}, 32'h07);
        collector_finished = 1'b1;
        @(negedge clk);
        collector_finished = 1'b0;
        checkOutput("t2_st_preclear", {31'd0, store_req}, 32'd0);
        checkOutput("t2_busy_clr", {24'd0, busy_regs}, 32'd0);
        @(negedge clk);
        checkOutput("t2_st_req", {31'd0, store_req}, 32'd1);
        checkOutput("t2_st_addr", {29'd0, store_addr}, 32'd2);
        mem_store_en = 1'b1;
        @(negedge clk);
        mem_store_en = 1'b0;
        @(negedge clk);
        checkOutput("t2_st_done", {31'd0, store_req}, 32'd0);
        checkOutput("t2_idle", {31'd0, idle}, 32'd1);

        // Independent load runs beside the multiply, dependent one stalls
        issueMult(3'd0, 3'd1, 3'd2);
        applyStimulus(2'd1, 3'd0, 3'd0, 3'd5);
        @(negedge clk);
        checkOutput("t3_ld5_req", {28'd0, load_req, load_addr}, 32'hD);
        mem_load_ack = 1'b1;
        @(negedge clk);
        mem_load_ack = 1'b0;
        @(negedge clk);
        checkOutput("t3_ld5_done", {31'd0, load_req}, 32'd0);
        applyStimulus(2'd1, 3'd0, 3'd0, 3'd1);
        stepCycles(3);
        checkOutput("t3_ld1_stall", {31'd0, load_req}, 32'd0);
        collector_finished = 1'b1;
        @(negedge clk);
        collector_finished = 1'b0;
        checkOutput("t3_ld1_preclear", {31'd0, load_req}, 32'd0);
        @(negedge clk);
        checkOutput("t3_ld1_req", {28'd0, load_req, load_addr}, 32'h9);
        mem_load_ack = 1'b1;
        @(negedge clk);
        mem_load_ack = 1'b0;
        @(negedge clk);
        checkOutput("t3_idle", {31'd0, idle}, 32'd1);

        // Fill the queue behind stalled stores
        issueMult(3'd0, 3'd1, 3'd2);
        for (int i = 0; i < 4; i++) applyStimulus(2'd2, 3'd2, 3'd0, 3'd0);
        checkOutput("t4_full", {31'd0, op_ready}, 32'd0);
        op_valid = 1'b1;
        op_code  = 2'd2;
        op_src0  = 3'd3;
        stepCycles(2);
        checkOutput("t4_held", {31'd0, op_ready}, 32'd0);
        collector_finished = 1'b1;
        @(negedge clk);
        collector_finished = 1'b0;
        checkOutput("t4_still_full", {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        checkOutput("t4_ready_after_pop", {31'd0, op_ready}, 32'd1);
        checkOutput("t4_st_req", {31'd0, store_req}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("t4_refull", {31'd0, op_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("t4_rst_ready", {31'd0, op_ready}, 32'd1);
        checkOutput("t4_rst_store", {31'd0, store_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t4_flushed", {30'd0, idle, op_ready}, 32'd3);

        // Multiply never accepted: timeout aborts it and the NOP behind drains
        applyStimulus(2'd3, 3'd0, 3'd1, 3'd2);
        applyStimulus(2'd0, 3'd0, 3'd0, 3'd0);
        checkOutput("t5_start", {31'd0, start_mult}, 32'd1);
        checkOutput("t5_not_idle", {31'd0, idle}, 32'd0);
        stepCycles(1000);
        checkOutput("t5_still_waiting", {30'd0, start_mult, timeout_err}, 32'd2);
        stepCycles(30);
        checkOutput("t5_aborted", {30'd0, start_mult, timeout_err}, 32'd1);
        checkOutput("t5_no_mult_out", {24'd0, busy_regs}, 32'd0);
        checkOutput("t5_nop_drained", {31'd0, idle}, 32'd1);

        // Asynchronous reset in the middle of a load transfer
        issueMult(3'd3, 3'd6, 3'd7);
        checkOutput("t6_busy", {24'd0, busy_regs}, 32'hC8);
        applyStimulus(2'd1, 3'd0, 3'd0, 3'd4);
        @(negedge clk);
        checkOutput("t6_ld_req", {28'd0, load_req, load_addr}, 32'hC);
        mem_load_ack = 1'b1;
        @(negedge clk);
        checkOutput("t6_xfer_sticky", {30'd0, load_req, timeout_err}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_ld", {31'd0, load_req}, 32'd0);
        checkOutput("t6_rst_busy", {24'd0, busy_regs}, 32'd0);
        checkOutput("t6_rst_flags", {29'd0, timeout_err, idle, op_ready}, 32'd3);
        mem_load_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_after", {29'd0, load_req, idle, op_ready}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
